nanci_sort_sequencer: RTL and testbench

//  Global phase controller for the Nanci PE mesh (SQRT_N x SQRT_N PEs).

---
 rtl/nanci_pkg.sv | 28 ++
 rtl/nanci_step_timer.sv | 68 ++++++
 rtl/nanci_sort_sequencer.sv | 152 +++++++++++++++
 tb/tb_nanci_sort_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/nanci_pkg.sv
// Shared encodings for the Nanci mesh sort sequencer: FSM states and the
// axis / parity values broadcast to every PE.
package nanci_pkg;

   // Sequencer phases, in run order.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ROW   = 3'd2,
      S_COL   = 3'd3,
      S_FINAL = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   // Exchange direction seen by the PEs.
   localparam logic AXIS_ROW = 1'b0;
   localparam logic AXIS_COL = 1'b1;

   // Which neighbour pairs exchange on a step.
   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // True for the three compare-exchange phases.
   function automatic logic is_sort_phase(input state_e s);
      return (s == S_ROW) || (s == S_COL) || (s == S_FINAL);
   endfunction

endpackage

// File: rtl/nanci_step_timer.sv
// Step timer for one sort phase: each of SQRT_N steps lasts COMPUTE_CYCLES
// cycles. Flags the commit cycle of each step, the current pair parity and
// the commit cycle of the last step in the phase.
module nanci_step_timer
   import nanci_pkg::*;
#(
   parameter int SQRT_N         = 4,
   parameter int COMPUTE_CYCLES = 1,
   parameter int CNT_WIDTH      = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic clear_i,
   output logic step_valid_o,
   output logic parity_o,
   output logic phase_last_o
);

   localparam logic [CNT_WIDTH-1:0] LAST_CYC  = CNT_WIDTH'(COMPUTE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(SQRT_N - 1);

   logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
   logic [CNT_WIDTH-1:0] step_q, step_d;
   logic                 parity_q, parity_d;

   // Commit strobes come straight from the counters so they fall with reset.
   assign step_valid_o = run_i && (cyc_q == LAST_CYC);
   assign phase_last_o = step_valid_o && (step_q == LAST_STEP);
   assign parity_o     = parity_q;

   // Advance cycle-within-step, then step-within-phase; parity follows the step.
   always_comb begin
      cyc_d    = cyc_q;
      step_d   = step_q;
      parity_d = parity_q;
      if (clear_i || !run_i) begin
         cyc_d    = '0;
         step_d   = '0;
         parity_d = PARITY_EVEN;
      end else if (step_valid_o) begin
         cyc_d = '0;
         if (phase_last_o) begin
            step_d   = '0;
            parity_d = PARITY_EVEN;
         end else begin
            step_d   = step_q + CNT_WIDTH'(1);
            parity_d = ~parity_q;
         end
      end else begin
         cyc_d = cyc_q + CNT_WIDTH'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_q    <= '0;
         step_q   <= '0;
         parity_q <= PARITY_EVEN;
      end else begin
         cyc_q    <= cyc_d;
         step_q   <= step_d;
         parity_q <= parity_d;
      end
   end

endmodule

// File: rtl/nanci_sort_sequencer.sv
// Global phase controller for the Nanci PE mesh. Sweeps the PE memory load
// addresses, then runs shearsort as (LOG_SQRT_N+1) rounds of row and column
// odd-even transposition phases followed by one final row phase.
// Snake ordering is resolved inside the PEs.
module nanci_sort_sequencer
   import nanci_pkg::*;
#(
   parameter int SQRT_N         = 4,
   parameter int LOG_SQRT_N     = 2,
   parameter int ADDR_WIDTH     = 3,
   parameter int COMPUTE_CYCLES = 1,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic                  i_abort,
   output logic                  o_busy,
   output logic                  o_load_en,
   output logic [ADDR_WIDTH-1:0] o_load_addr,
   output logic                  o_axis,
   output logic                  o_parity,
   output logic                  o_step_valid,
   output logic [CNT_WIDTH-1:0]  o_round,
   output logic                  o_done,
   output logic [2:0]            o_dbg_state
);

   localparam logic [CNT_WIDTH-1:0] LAST_ROUND = CNT_WIDTH'(LOG_SQRT_N);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
   logic [CNT_WIDTH-1:0]  round_q, round_d;
   logic                  busy_q, busy_d;
   logic                  load_en_q, load_en_d;
   logic                  axis_q, axis_d;
   logic                  done_q, done_d;

   logic                  timer_step_valid;
   logic                  timer_parity;
   logic                  timer_phase_last;

   nanci_step_timer #(
      .SQRT_N         (SQRT_N),
      .COMPUTE_CYCLES (COMPUTE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_step_timer (
      .clk          (clk),
      .rst          (rst),
      .run_i        (is_sort_phase(state_q)),
      .clear_i      (i_abort),
      .step_valid_o (timer_step_valid),
      .parity_o     (timer_parity),
      .phase_last_o (timer_phase_last)
   );

   // Next state, counters and the output values that go with the next state.
   always_comb begin
      state_d     = state_q;
      load_addr_d = load_addr_q;
      round_d     = round_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d     = S_LOAD;
               load_addr_d = '0;
               round_d     = '0;
            end
         end
         S_LOAD: begin
            if (&load_addr_q) begin
               state_d     = S_ROW;
               load_addr_d = '0;
               round_d     = '0;
            end else begin
               load_addr_d = load_addr_q + ADDR_WIDTH'(1);
            end
         end
         S_ROW: begin
            if (timer_phase_last) state_d = S_COL;
         end
         S_COL: begin
            if (timer_phase_last) begin
               if (round_q < LAST_ROUND) begin
                  state_d = S_ROW;
                  round_d = round_q + CNT_WIDTH'(1);
               end else begin
                  state_d = S_FINAL;
               end
            end
         end
         S_FINAL: begin
            if (timer_phase_last) begin
               state_d = S_DONE;
               round_d = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d     = S_IDLE;
            load_addr_d = '0;
            round_d     = '0;
         end
      endcase

      // Abort wins over start and over any phase advance.
      if (i_abort) begin
         state_d     = S_IDLE;
         load_addr_d = '0;
         round_d     = '0;
      end

      busy_d    = (state_d != S_IDLE);
      load_en_d = (state_d == S_LOAD);
      axis_d    = (state_d == S_COL) ? AXIS_COL : AXIS_ROW;
      done_d    = (state_d == S_DONE);
   end

   // FSM and registered broadcast outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         load_addr_q <= '0;
         round_q     <= '0;
         busy_q      <= 1'b0;
         load_en_q   <= 1'b0;
         axis_q      <= AXIS_ROW;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_addr_q <= load_addr_d;
         round_q     <= round_d;
         busy_q      <= busy_d;
         load_en_q   <= load_en_d;
         axis_q      <= axis_d;
         done_q      <= done_d;
      end
   end

   assign o_busy       = busy_q;
   assign o_load_en    = load_en_q;
   assign o_load_addr  = load_addr_q;
   assign o_axis       = axis_q;
   assign o_parity     = timer_parity;
   assign o_step_valid = timer_step_valid;
   assign o_round      = round_q;
   assign o_done       = done_q;
   assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_nanci_sort_sequencer.sv
// Bench for nanci_sort_sequencer: two instances (COMPUTE_CYCLES 1 and 3)
// share stimulus; each is compared cycle by cycle against a trace computed
// from the phase schedule.
module tb_nanci_sort_sequencer;

   localparam int SQRT_N = 4;
   localparam int LOG    = 2;
   localparam int AW     = 3;
   localparam int CW     = 8;
   localparam int RUN_CYCLES = 97;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_start = 1'b0;
   logic i_abort = 1'b0;

   logic          busy1, load_en1, axis1, parity1, sv1, done1;
   logic [AW-1:0] addr1;
   logic [CW-1:0] round1;
   logic [2:0]    state1;
   logic          busy3, load_en3, axis3, parity3, sv3, done3;
   logic [AW-1:0] addr3;
   logic [CW-1:0] round3;
   logic [2:0]    state3;

   int total_cnt = 0;
   int bad_cnt   = 0;

   // Clock.
   always #5 clk = ~clk;

   nanci_sort_sequencer #(
      .SQRT_N(SQRT_N), .LOG_SQRT_N(LOG), .ADDR_WIDTH(AW),
      .COMPUTE_CYCLES(1), .CNT_WIDTH(CW)
   ) u_dut_c1 (
      .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
      .o_busy(busy1), .o_load_en(load_en1), .o_load_addr(addr1),
      .o_axis(axis1), .o_parity(parity1), .o_step_valid(sv1),
      .o_round(round1), .o_done(done1), .o_dbg_state(state1)
   );

   nanci_sort_sequencer #(
      .SQRT_N(SQRT_N), .LOG_SQRT_N(LOG), .ADDR_WIDTH(AW),
      .COMPUTE_CYCLES(3), .CNT_WIDTH(CW)
   ) u_dut_c3 (
      .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
      .o_busy(busy3), .o_load_en(load_en3), .o_load_addr(addr3),
      .o_axis(axis3), .o_parity(parity3), .o_step_valid(sv3),
      .o_round(round3), .o_done(done3), .o_dbg_state(state3)
   );

   wire [31:0] act1 = 32'({busy1, load_en1, addr1, axis1, parity1, sv1, round1, done1});
   wire [31:0] act3 = 32'({busy3, load_en3, addr3, axis3, parity3, sv3, round3, done3});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs on cycle k of a run (k=0 is the first LOAD cycle),
   // for compute length c; a run aborted on cycle abort_at is idle afterwards.
   function automatic logic [31:0] exp_vec(input int c, input int k, input int abort_at);
      int n_load, phase_len, n_phase, total, j, ph, r;
      logic busy, len, ax, par, sv, dn;
      logic [AW-1:0] addr;
      logic [CW-1:0] rnd;
      n_load    = 1 << AW;
      phase_len = SQRT_N * c;
      n_phase   = 2 * (LOG + 1) + 1;
      total     = n_load + n_phase * phase_len + 1;
      busy = 0; len = 0; ax = 0; par = 0; sv = 0; dn = 0; addr = '0; rnd = '0;
      if (k >= 0 && k < total && !(abort_at >= 0 && k > abort_at)) begin
         busy = 1;
         if (k < n_load) begin
            len  = 1;
            addr = AW'(k);
         end else if (k < n_load + n_phase * phase_len) begin
            j   = k - n_load;
            ph  = j / phase_len;
            r   = j % phase_len;
            ax  = (ph != n_phase - 1) && (ph % 2 == 1);
            rnd = CW'((ph == n_phase - 1) ? LOG : ph / 2);
            par = ((r / c) % 2) == 1;
            sv  = (r % c) == (c - 1);
         end else begin
            dn = 1;
         end
      end
      return 32'({busy, len, addr, ax, par, sv, rnd, dn});
   endfunction

   // One run: start pulse, optional abort, optional held start or start noise.
   task automatic run_seq(input int abort_at, input bit hold, input bit noise);
      int n_sv1, n_sv3, done_k1, done_k3;
      n_sv1 = 0; n_sv3 = 0; done_k1 = -1; done_k3 = -1;
      i_start = 1'b1;
      i_abort = 1'b0;
      for (int k = 0; k < RUN_CYCLES; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("trace_c1", act1, exp_vec(1, k, abort_at));
         check("trace_c3", act3, exp_vec(3, k, abort_at));
         if (sv1) n_sv1++;
         if (sv3) n_sv3++;
         if (done1 && done_k1 < 0) done_k1 = k;
         if (done3 && done_k3 < 0) done_k3 = k;
         i_start = 1'b0;
         if (hold && k <= 36) i_start = 1'b1;
         if (noise && k <= 35 && $urandom_range(0, 3) == 0) i_start = 1'b1;
         if (abort_at >= 0 && k >= abort_at) i_start = 1'b0;
         i_abort = (k == abort_at);
      end
      i_start = 1'b0;
      i_abort = 1'b0;
      if (abort_at < 0) begin
         check("steps_c1", 32'(n_sv1), 32'd28);
         check("steps_c3", 32'(n_sv3), 32'd28);
         check("done_cycle_c1", 32'(done_k1), 32'd36);
         check("done_cycle_c3", 32'(done_k3), 32'd92);
      end else if (abort_at < 36) begin
         check("no_done_c1", 32'(done_k1), 32'hFFFF_FFFF);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_c1", act1, 32'd0);
         check("idle_c3", act3, 32'd0);
      end
   endtask

   initial begin
      // Reset, then ten idle cycles with no start.
      rst = 1'b0;
      #2;
      check("reset_c1", act1, 32'd0);
      check("reset_c3", act3, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle_cycles(10);

      // Clean run, abort in round-1 column step 2, rerun, held start.
      run_seq(-1, 1'b0, 1'b0);
      run_seq(21, 1'b0, 1'b0);
      run_seq(-1, 1'b0, 1'b0);
      run_seq(-1, 1'b1, 1'b0);
      idle_cycles(3);

      // Randomised runs: random idle gaps, random abort points, start noise.
      repeat (6) begin
         int gap, ab;
         gap = $urandom_range(0, 5);
         ab  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, RUN_CYCLES - 2));
         idle_cycles(gap);
         run_seq(ab, 1'b0, 1'b1);
      end

      // Start together with abort in IDLE stays idle; abort alone does nothing.
      i_start = 1'b1;
      i_abort = 1'b1;
      idle_cycles(1);
      i_start = 1'b0;
      idle_cycles(2);
      i_abort = 1'b0;
      idle_cycles(1);

      // Asynchronous reset in the middle of LOAD.
      i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("load_before_rst_c1", 32'(load_en1), 32'd1);
      check("addr_before_rst_c1", 32'(addr1), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("load_en_async_c1", 32'(load_en1), 32'd0);
      check("load_en_async_c3", 32'(load_en3), 32'd0);
      check("busy_async_c1", 32'(busy1), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(3);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
